hpi_access_ctrl: RTL and testbench
==================================

HPI_ACCESS_CTRL -- requirements
Module: hpi_access_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: clocks CS_N/ADDR/data valid before strobe (range 1..15).
REQ-002 SHALL have parameter STROBE_CYC, default 4: clocks RD_N/WR_N held low (range 1..15).
REQ-003 SHALL have parameter HOLD_CYC, default 2: clocks CS_N/ADDR/data held after strobe rises (range 1..15).
REQ-004 SHALL have parameter RST_CYC, default 1000: clocks OTG_RST_N held low after reset release (range 1..65535).
REQ-005 SHALL have these ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- avs_address  in  2  HPI register select.
- avs_read  in  1  Avalon read request.
- avs_write  in  1  Avalon write request.
- avs_writedata  in  16  write data.
- avs_readdata  out  16  read data.
- avs_waitrequest  out  1  stall.
- irq  out  1  HPI interrupt to CPU.
- OTG_ADDR  out  2  HPI address.
- OTG_CS_N  out  1  chip select, active low.
- OTG_RD_N  out  1  read strobe, active low.
- OTG_WR_N  out  1  write strobe, active low.
- OTG_RST_N  out  1  CY7C67200 reset, active low.
- OTG_DATA_out  out  16  data to pad.
- OTG_DATA_oe  out  1  pad output enable; top level drives OTG_DATA with OTG_DATA_out when high, else Z.
- OTG_DATA_in  in  16  data from pad.
- OTG_INT  in  1  CY7C67200 interrupt, asynchronous.

Function
REQ-006 SHALL implement states RSTP (reset pulse), IDLE, SETUP, STROBE, HOLD, DONE, with one shared 16-bit down-counter.
REQ-007 RSTP SHALL drive OTG_RST_N=0 for RST_CYC clocks, then go to IDLE and set OTG_RST_N=1; requests present during RSTP SHALL stall.
REQ-008 IDLE with avs_write=1 SHALL accept a write; with only avs_read=1 SHALL accept a read; when both are 1, the write SHALL win.
REQ-009 On acceptance: latch address/data; register OTG_ADDR, OTG_CS_N=0 and OTG_DATA_oe=1 (writes only); enter SETUP for SETUP_CYC clocks.
REQ-010 STROBE SHALL hold OTG_WR_N=0 (write) or OTG_RD_N=0 (read) for STROBE_CYC clocks; on its final clock OTG_DATA_in SHALL be registered to avs_readdata (reads only).
REQ-011 HOLD SHALL raise the strobe and keep CS_N, ADDR, data and oe unchanged for HOLD_CYC clocks.
REQ-012 DONE SHALL last one clock: OTG_CS_N=1, OTG_DATA_oe=0, avs_waitrequest=0; next state IDLE.
REQ-013 avs_waitrequest SHALL be (avs_read|avs_write) AND state!=DONE, combinational from registered state.
REQ-014 Acceptance-to-waitrequest-low latency SHALL be 1+SETUP_CYC+STROBE_CYC+HOLD_CYC clocks (9 at defaults); CS_N SHALL be high for at least 2 clocks between transactions.
REQ-015 All OTG_* outputs SHALL be registered and glitch-free; RD_N and WR_N SHALL never be low together; strobe SHALL be low only while CS_N is low.
REQ-016 avs_readdata SHALL hold its value until the next read completes; writes SHALL NOT change it.

Reset
REQ-017 reset_n=0 SHALL immediately force: state RSTP, OTG_CS_N/RD_N/WR_N=1, OTG_RST_N=0, OTG_DATA_oe=0, OTG_ADDR=0, OTG_DATA_out=0, avs_readdata=0, irq=0, counter=RST_CYC.
REQ-018 reset_n asserted mid-transaction SHALL abort the transaction with no further strobe; after release, RSTP SHALL run its full length.

Configuration
REQ-019 With HPI_IRQ_SYNC_EN defined, OTG_INT SHALL pass through a 2-flop synchronizer (irq follows OTG_INT after 2 clocks); undefined, irq SHALL equal OTG_INT combinationally.

Verification
REQ-020 RST_CYC=16; release reset_n -> OTG_RST_N low exactly 16 clocks; write issued at clock 3 keeps waitrequest=1 until after RSTP.
REQ-021 Defaults; write addr 2, data 0x1234 -> OTG_ADDR=2, CS_N low 8 clocks, WR_N low clocks 3-6 of those, oe=1 and OTG_DATA_out=0x1234 throughout, waitrequest low on 9th clock.
REQ-022 Read addr 0, OTG_DATA_in=0xBEEF during STROBE -> RD_N low 4 clocks, oe stays 0, avs_readdata=0xBEEF in DONE cycle.
REQ-023 Write, then read issued back-to-back -> CS_N high 2 clocks between the transactions; avs_read and avs_write both 1 -> write cycle, avs_readdata unchanged.
REQ-024 reset_n=0 during STROBE of a write -> WR_N=1, CS_N=1, oe=0, OTG_RST_N=0 without waiting for a clock edge.
REQ-025 OTG_INT 0->1 -> irq=1 after 2 clocks with HPI_IRQ_SYNC_EN, in the same cycle without.

Source files
------------

// File: rtl/hpi_access_ctrl.sv
// Avalon-MM slave to CY7C67200 HPI bridge: paced setup/strobe/hold bus cycles and an OTG reset pulse.
// Optional macro HPI_IRQ_SYNC_EN: route OTG_INT through a 2-flop synchronizer before irq.
module hpi_access_ctrl #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int RST_CYC    = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        irq,
    output logic [1:0]  OTG_ADDR,
    output logic        OTG_CS_N,
    output logic        OTG_RD_N,
    output logic        OTG_WR_N,
    output logic        OTG_RST_N,
    output logic [15:0] OTG_DATA_out,
    output logic        OTG_DATA_oe,
    input  logic [15:0] OTG_DATA_in,
    input  logic        OTG_INT
);

    typedef enum logic [2:0] {RSTP, IDLE, SETUP, STROBE, HOLD, DONE} state_t;

    localparam logic [15:0] SETUP_LD  = 16'(SETUP_CYC);
    localparam logic [15:0] STROBE_LD = 16'(STROBE_CYC);
    localparam logic [15:0] HOLD_LD   = 16'(HOLD_CYC);
    localparam logic [15:0] RST_LD    = 16'(RST_CYC);

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        wr_reg, wr_next;
    logic [1:0]  addr_reg, addr_next;
    logic [15:0] dout_reg, dout_next;
    logic [15:0] rdata_reg, rdata_next;
    logic        cs_n_reg, cs_n_next;
    logic        rd_n_reg, rd_n_next;
    logic        wr_n_reg, wr_n_next;
    logic        rst_n_reg, rst_n_next;
    logic        oe_reg, oe_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= RSTP;
            cnt_reg   <= RST_LD;
            wr_reg    <= 1'b0;
            addr_reg  <= 2'd0;
            dout_reg  <= 16'd0;
            rdata_reg <= 16'd0;
            cs_n_reg  <= 1'b1;
            rd_n_reg  <= 1'b1;
            wr_n_reg  <= 1'b1;
            rst_n_reg <= 1'b0;
            oe_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            wr_reg    <= wr_next;
            addr_reg  <= addr_next;
            dout_reg  <= dout_next;
            rdata_reg <= rdata_next;
            cs_n_reg  <= cs_n_next;
            rd_n_reg  <= rd_n_next;
            wr_n_reg  <= wr_n_next;
            rst_n_reg <= rst_n_next;
            oe_reg    <= oe_next;
        end
    end

    // Each timed phase loads its length and exits on the clock where the count reaches 1.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_next    = wr_reg;
        addr_next  = addr_reg;
        dout_next  = dout_reg;
        rdata_next = rdata_reg;
        cs_n_next  = cs_n_reg;
        rd_n_next  = rd_n_reg;
        wr_n_next  = wr_n_reg;
        rst_n_next = rst_n_reg;
        oe_next    = oe_reg;
        case (state_reg)
            RSTP: begin
                if (cnt_reg <= 16'd1) begin
                    state_next = IDLE;
                    rst_n_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            IDLE: begin
                if (avs_write || avs_read) begin
                    wr_next    = avs_write;
                    addr_next  = avs_address;
                    if (avs_write) begin
                        dout_next = avs_writedata;
                    end
                    cs_n_next  = 1'b0;
                    oe_next    = avs_write;
                    cnt_next   = SETUP_LD;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (cnt_reg <= 16'd1) begin
                    state_next = STROBE;
                    cnt_next   = STROBE_LD;
                    if (wr_reg) begin
                        wr_n_next = 1'b0;
                    end else begin
                        rd_n_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            STROBE: begin
                if (cnt_reg <= 16'd1) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LD;
                    wr_n_next  = 1'b1;
                    rd_n_next  = 1'b1;
                    // Pad data is captured while RD_N is still low.
                    if (!wr_reg) begin
                        rdata_next = OTG_DATA_in;
                    end
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            HOLD: begin
                if (cnt_reg <= 16'd1) begin
                    state_next = DONE;
                    cs_n_next  = 1'b1;
                    oe_next    = 1'b0;
                end else begin
                    cnt_next = cnt_reg - 16'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = RSTP;
            end
        endcase
    end

    assign avs_waitrequest = (avs_read | avs_write) && (state_reg != DONE);
    assign avs_readdata    = rdata_reg;
    assign OTG_ADDR        = addr_reg;
    assign OTG_CS_N        = cs_n_reg;
    assign OTG_RD_N        = rd_n_reg;
    assign OTG_WR_N        = wr_n_reg;
    assign OTG_RST_N       = rst_n_reg;
    assign OTG_DATA_out    = dout_reg;
    assign OTG_DATA_oe     = oe_reg;

`ifdef HPI_IRQ_SYNC_EN
    logic [1:0] irq_sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_sync_reg <= 2'b00;
        end else begin
            irq_sync_reg <= {irq_sync_reg[0], OTG_INT};
        end
    end

    assign irq = irq_sync_reg[1];
`else
    // Unsynchronized pass-through, still forced low while reset is held.
    assign irq = OTG_INT & reset_n;
`endif

endmodule

// File: tb/tb_hpi_access_ctrl.sv
// Directed bench for hpi_access_ctrl: reset pulse, table of bus transactions, mid-strobe reset, irq path.
module tb_hpi_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [15:0] avs_writedata;
    logic [15:0] avs_readdata;
    logic        avs_waitrequest;
    logic        irq;
    logic [1:0]  OTG_ADDR;
    logic        OTG_CS_N;
    logic        OTG_RD_N;
    logic        OTG_WR_N;
    logic        OTG_RST_N;
    logic [15:0] OTG_DATA_out;
    logic        OTG_DATA_oe;
    logic [15:0] OTG_DATA_in;
    logic        OTG_INT;
    logic [15:0] din_val;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // The pad only shows valid data while RD_N is low, so a mistimed capture is visible.
    assign OTG_DATA_in = OTG_RD_N ? 16'h0BAD : din_val;

    hpi_access_ctrl #(
        .SETUP_CYC (2),
        .STROBE_CYC(4),
        .HOLD_CYC  (2),
        .RST_CYC   (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avs_address    (avs_address),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .avs_waitrequest(avs_waitrequest),
        .irq            (irq),
        .OTG_ADDR       (OTG_ADDR),
        .OTG_CS_N       (OTG_CS_N),
        .OTG_RD_N       (OTG_RD_N),
        .OTG_WR_N       (OTG_WR_N),
        .OTG_RST_N      (OTG_RST_N),
        .OTG_DATA_out   (OTG_DATA_out),
        .OTG_DATA_oe    (OTG_DATA_oe),
        .OTG_DATA_in    (OTG_DATA_in),
        .OTG_INT        (OTG_INT)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] din;
        logic [15:0] exp_rdata;
        int          exp_wr_low;
        int          exp_rd_low;
        logic        exp_oe;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Applies one request in the current IDLE cycle and monitors it to completion.
    task automatic txn(input vec_t v, input int idx);
        int cs_low = 0, wr_low = 0, rd_low = 0;
        int first_cs = -1, first_stb = -1, lat = -1;
        int addr_bad = 0, data_bad = 0, viol = 0;
        avs_read      = v.rd;
        avs_write     = v.wr;
        avs_address   = v.addr;
        avs_writedata = v.wdata;
        din_val       = v.din;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                lat = c;
                chk($sformatf("v%0d done_cs_n", idx), int'(OTG_CS_N), 1);
                chk($sformatf("v%0d done_oe", idx), int'(OTG_DATA_oe), 0);
                chk($sformatf("v%0d readdata", idx), int'(avs_readdata), int'(v.exp_rdata));
                break;
            end
            if (!OTG_CS_N) begin
                cs_low++;
                if (first_cs < 0) first_cs = c;
                if (OTG_ADDR != v.addr) addr_bad++;
                if (OTG_DATA_oe != v.exp_oe) data_bad++;
                if (v.exp_oe && OTG_DATA_out != v.wdata) data_bad++;
            end else if (OTG_DATA_oe) begin
                data_bad++;
            end
            if (!OTG_WR_N) begin
                wr_low++;
                if (first_stb < 0) first_stb = c;
            end
            if (!OTG_RD_N) begin
                rd_low++;
                if (first_stb < 0) first_stb = c;
            end
            if (!OTG_WR_N && !OTG_RD_N) viol++;
            if ((!OTG_WR_N || !OTG_RD_N) && OTG_CS_N) viol++;
        end
        @(posedge clk);
        #1;
        avs_read  = 1'b0;
        avs_write = 1'b0;
        chk($sformatf("v%0d latency", idx), lat, 9);
        chk($sformatf("v%0d cs_low_clocks", idx), cs_low, 8);
        chk($sformatf("v%0d cs_first_low", idx), first_cs, 1);
        chk($sformatf("v%0d wr_low_clocks", idx), wr_low, v.exp_wr_low);
        chk($sformatf("v%0d rd_low_clocks", idx), rd_low, v.exp_rd_low);
        chk($sformatf("v%0d strobe_first_low", idx), first_stb, 3);
        chk($sformatf("v%0d addr_errors", idx), addr_bad, 0);
        chk($sformatf("v%0d data_oe_errors", idx), data_bad, 0);
        chk($sformatf("v%0d strobe_violations", idx), viol, 0);
        $display("txn %0d rd=%0d wr=%0d addr=%0d wdata=0x%04h readdata=0x%04h lat=%0d", idx, v.rd, v.wr,
                 v.addr, v.wdata, avs_readdata, lat);
    endtask

    initial begin
        int rst_low, stall_bad, c, seen;
        vecs[0] = '{1'b0, 1'b1, 2'd2, 16'h1234, 16'h0000, 16'h0000, 4, 0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'hBEEF, 16'hBEEF, 0, 4, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 2'd1, 16'h5A5A, 16'h7777, 16'hBEEF, 4, 0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 2'd3, 16'h0000, 16'h0F0F, 16'h0F0F, 0, 4, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 2'd1, 16'hFFFF, 16'h0000, 16'h0F0F, 4, 0, 1'b1};

        reset_n       = 1'b0;
        avs_address   = 2'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 16'd0;
        din_val       = 16'd0;
        OTG_INT       = 1'b1;

        // Reset state, with OTG_INT high to show irq is held low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst cs_n", int'(OTG_CS_N), 1);
        chk("rst rd_n", int'(OTG_RD_N), 1);
        chk("rst wr_n", int'(OTG_WR_N), 1);
        chk("rst otg_rst_n", int'(OTG_RST_N), 0);
        chk("rst oe", int'(OTG_DATA_oe), 0);
        chk("rst addr", int'(OTG_ADDR), 0);
        chk("rst data_out", int'(OTG_DATA_out), 0);
        chk("rst readdata", int'(avs_readdata), 0);
        chk("rst irq", int'(irq), 0);
        $display("reset state checked");
        OTG_INT = 1'b0;

        // Reset pulse length; a write issued early must stall until IDLE.
        reset_n   = 1'b1;
        rst_low   = 0;
        stall_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (OTG_RST_N) break;
            rst_low++;
            if (avs_write && !avs_waitrequest) stall_bad++;
            if (!OTG_CS_N) stall_bad++;
            @(posedge clk);
            #1;
            if (i == 2) begin
                avs_write     = 1'b1;
                avs_address   = 2'd1;
                avs_writedata = 16'hAAAA;
            end
        end
        chk("rstp low_clocks", rst_low, 16);
        chk("rstp stall_errors", stall_bad, 0);
        c = 0;
        while (avs_waitrequest && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("rstp write latency", c, 9);
        chk("rstp write readdata", int'(avs_readdata), 0);
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        $display("reset pulse %0d clocks, queued write latency %0d", rst_low, c);

        // Back-to-back table transactions.
        for (int i = 0; i < 5; i++) begin
            txn(vecs[i], i);
        end

        // Reset asserted while a write strobe is low.
        avs_write     = 1'b1;
        avs_address   = 2'd3;
        avs_writedata = 16'hC3C3;
        seen          = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!OTG_WR_N) begin
                seen = 1;
                break;
            end
        end
        chk("abort strobe_reached", seen, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort wr_n", int'(OTG_WR_N), 1);
        chk("abort cs_n", int'(OTG_CS_N), 1);
        chk("abort oe", int'(OTG_DATA_oe), 0);
        chk("abort otg_rst_n", int'(OTG_RST_N), 0);
        chk("abort readdata", int'(avs_readdata), 0);
        avs_write = 1'b0;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        rst_low   = 0;
        stall_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (OTG_RST_N) break;
            rst_low++;
            if (!OTG_WR_N || !OTG_CS_N) stall_bad++;
        end
        chk("abort rstp low_clocks", rst_low, 16);
        chk("abort no_strobe", stall_bad, 0);
        $display("mid-strobe reset: pulse %0d clocks", rst_low);

        // Interrupt path.
        @(posedge clk);
        #1;
        OTG_INT = 1'b1;
`ifdef HPI_IRQ_SYNC_EN
        #1;
        chk("irq sync 0clk", int'(irq), 0);
        @(posedge clk);
        #1;
        chk("irq sync 1clk", int'(irq), 0);
        @(posedge clk);
        #1;
        chk("irq sync 2clk", int'(irq), 1);
        OTG_INT = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("irq sync clear", int'(irq), 0);
`else
        #1;
        chk("irq comb rise", int'(irq), 1);
        OTG_INT = 1'b0;
        #1;
        chk("irq comb fall", int'(irq), 0);
`endif
        $display("irq path checked");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
